instr_fetch_queue: RTL and testbench

- Front end of the out-of-order core. Produces instructions for the decoder/control path.
- Owns the PC and issues sequential reads to instruction memory, which has fixed one-cycle latency.
- Buffers returned words in a small FIFO and hands them to decode with a valid/ready handshake.
- Branch resolution redirects the PC; the block flushes all buffered and in-flight instructions.

---
 rtl/instr_fetch_queue_pkg.sv | 25 ++
 rtl/instr_fetch_queue_if.sv | 46 ++++
 rtl/instr_fetch_queue_fifo.sv | 68 ++++++
 rtl/instr_fetch_queue.sv | 101 ++++++++++
 tb/tb_instr_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_queue_pkg.sv
//------------------------------------------------------------------------------
// Module   : core_pkg
// Purpose  : Shared core-wide constants and types for the fetch front end and
//            later pipeline stages (issue queue reuses the same entry layout).
// Contents : PC_W, INSTR_W, INSTR_BYTES, INSTR_ALIGN_BITS, fetch_entry_t
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package core_pkg;

   localparam int PC_W             = 64;
   localparam int INSTR_W          = 32;
   localparam int INSTR_BYTES      = 4;
   localparam int INSTR_ALIGN_BITS = $clog2(INSTR_BYTES);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_queue_if.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch_queue_if
// Purpose  : Bundles the instruction-memory, redirect and decode-side signals
//            of the fetch queue.
// Modports : master - the fetch queue (drives imem request and decode outputs)
//            slave  - the environment (imem, branch unit, decoder)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface instr_fetch_queue_if #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32
);
   logic                   imem_req;
   logic [PC_W-1:0]        imem_addr;
   logic [INSTR_W-1:0]     imem_rdata;
   logic                   redirect_valid;
   logic [PC_W-1:0]        redirect_pc;
   logic                   stall_fetch;
   logic                   fetch_valid;
   logic                   fetch_ready;
   logic [INSTR_W-1:0]     fetch_instr;
   logic [PC_W-1:0]        fetch_pc;
   logic [$clog2(DEPTH):0] occupancy;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata,
      input  redirect_valid, redirect_pc, stall_fetch,
      output fetch_valid, fetch_instr, fetch_pc, occupancy,
      input  fetch_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata,
      output redirect_valid, redirect_pc, stall_fetch,
      input  fetch_valid, fetch_instr, fetch_pc, occupancy,
      output fetch_ready
   );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_queue_fifo.sv
//------------------------------------------------------------------------------
// Module   : fetch_fifo
// Purpose  : Parameterised first-word-fall-through FIFO with flush.
// Ports    : clk, reset (async, active high)
//            i_push/i_push_data - enqueue
//            i_pop              - dequeue head (ignored when empty)
//            i_flush            - drop all entries; wins over push and pop
//            o_head             - head entry, zero while empty
//            o_empty, o_count   - status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_push_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output logic [WIDTH-1:0]       o_head,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !i_flush;
   assign w_pop   = i_pop && !i_flush && !o_empty;
   // Extra pointer MSB makes wr - rd the exact count, full included.
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
         end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch_queue
// Purpose  : Fetch front end. Owns the PC, issues sequential reads to a
//            one-cycle-latency instruction memory, buffers returned words and
//            hands them to decode. A redirect flushes buffered and in-flight
//            instructions and restarts fetch at the (aligned) target.
// Ports    : clk, reset (async, active high)
//            bus (master) - imem_req/addr/rdata, redirect_valid/pc,
//                           stall_fetch, fetch_valid/ready/instr/pc, occupancy
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module instr_fetch_queue #(
   parameter int              DEPTH    = 4,
   parameter int              PC_W     = core_pkg::PC_W,
   parameter int              INSTR_W  = core_pkg::INSTR_W,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_queue_if.master bus
);
   import core_pkg::*;

   localparam int PTR_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = PC_W + INSTR_W;

   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  r_req_pc;
   logic             r_inflight;
   logic             r_kill;

   logic             w_req;
   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic [PTR_W-1:0] w_count;
   logic [PTR_W:0]   w_credits_used;
   logic [ENT_W-1:0] w_head;
   logic [PC_W-1:0]  w_redirect_pc;

   // A request consumes a FIFO slot up front, so the returning word always fits.
   assign w_credits_used = {1'b0, w_count} + {{PTR_W{1'b0}}, r_inflight};
   assign w_req = !reset && !bus.redirect_valid && !bus.stall_fetch &&
                  (w_credits_used < (PTR_W+1)'(DEPTH));

   assign w_redirect_pc = {bus.redirect_pc[PC_W-1:INSTR_ALIGN_BITS],
                           {INSTR_ALIGN_BITS{1'b0}}};

   // Response lands the cycle after its request unless a redirect hit either
   // the request cycle (kill flag) or the response cycle itself.
   assign w_push = r_inflight && !r_kill && !bus.redirect_valid;
   // Decode handshakes during a redirect are void; the flush takes over.
   assign w_pop  = !w_empty && bus.fetch_ready && !bus.redirect_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_kill     <= 1'b0;
      end else begin
         r_inflight <= w_req;
         r_kill     <= bus.redirect_valid;
         if (w_req) begin
            r_req_pc <= r_pc;
         end
         if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
         end else if (w_req) begin
            r_pc <= r_pc + PC_W'(INSTR_BYTES);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data ({r_req_pc, bus.imem_rdata}),
      .i_pop       (w_pop),
      .i_flush     (bus.redirect_valid),
      .o_head      (w_head),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   assign bus.imem_req    = w_req;
   assign bus.imem_addr   = r_pc;
   assign bus.fetch_valid = !w_empty;
   assign bus.fetch_pc    = w_head[ENT_W-1 -: PC_W];
   assign bus.fetch_instr = w_head[INSTR_W-1:0];
   assign bus.occupancy   = w_count;
endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_fetch_queue
// Purpose  : Self-checking bench for instr_fetch_queue. Directed stimulus
//            pushes hand-computed expected requests and deliveries into
//            queues; negedge monitors pop and compare whenever the DUT issues
//            a request or completes a decode handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_instr_fetch_queue;
   import core_pkg::*;

   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   logic [63:0]  exp_req[$];
   fetch_entry_t exp_fetch[$];

   instr_fetch_queue_if #(.DEPTH(DEPTH), .PC_W(64), .INSTR_W(32)) bus ();

   instr_fetch_queue #(
      .DEPTH    (DEPTH),
      .PC_W     (64),
      .INSTR_W  (32),
      .RESET_PC (64'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: one-cycle latency, data = word address.
   always @(posedge clk) begin
      if (bus.imem_req) begin
         bus.imem_rdata <= bus.imem_addr[33:2];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic fetch_entry_t mk(input logic [63:0] pc, input logic [31:0] instr);
      fetch_entry_t e;
      e.pc    = pc;
      e.instr = instr;
      return e;
   endfunction

   // Request monitor
   always @(negedge clk) begin
      if (!reset && bus.imem_req) begin
         if (exp_req.size() == 0) begin
            check("unexpected_imem_req", bus.imem_addr, 64'hDEAD_BEEF);
         end else begin
            logic [63:0] a;
            a = exp_req.pop_front();
            check("imem_addr", bus.imem_addr, a);
         end
      end
   end

   // Delivery monitor
   always @(negedge clk) begin
      if (!reset && bus.fetch_valid && bus.fetch_ready && !bus.redirect_valid) begin
         if (exp_fetch.size() == 0) begin
            check("unexpected_fetch", bus.fetch_pc, 64'hDEAD_BEEF);
         end else begin
            fetch_entry_t e;
            e = exp_fetch.pop_front();
            check("fetch_pc", bus.fetch_pc, e.pc);
            check("fetch_instr", 64'(bus.fetch_instr), 64'(e.instr));
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Holds reset for two edges; returns at the start of cycle 0 after release.
   task automatic do_reset(input bit chk_state);
      reset              = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.stall_fetch    = 1'b0;
      bus.fetch_ready    = 1'b0;
      @(negedge clk);
      if (chk_state) begin
         check("rst_occupancy", 64'(bus.occupancy), 64'd0);
         check("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
         check("rst_imem_req", 64'(bus.imem_req), 64'd0);
         check("rst_fetch_pc", bus.fetch_pc, 64'd0);
         check("rst_fetch_instr", 64'(bus.fetch_instr), 64'd0);
         check("rst_imem_addr", bus.imem_addr, 64'd0);
      end
      next_cycle();
      next_cycle();
      exp_req.delete();
      exp_fetch.delete();
      reset = 1'b0;
   endtask

   task automatic check_drained(input string tname);
      check({tname, "_req_left"}, 64'(exp_req.size()), 64'd0);
      check({tname, "_fetch_left"}, 64'(exp_fetch.size()), 64'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // A: reset state, then streaming 0,4,..,28; valid at cycle 2, no bubbles
      do_reset(1'b1);
      bus.fetch_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_req.push_back(64'(4*k));
         exp_fetch.push_back(mk(64'(4*k), 32'(k)));
      end
      for (int c = 0; c < 12; c++) begin
         if (c == 8) bus.stall_fetch = 1'b1;
         @(negedge clk);
         if (c == 1) check("A_valid_c1", 64'(bus.fetch_valid), 64'd0);
         if (c >= 2 && c <= 9) check("A_no_bubble", 64'(bus.fetch_valid), 64'd1);
         if (c == 10) check("A_empty_c10", 64'(bus.fetch_valid), 64'd0);
         next_cycle();
      end
      check_drained("A");

      // B: backpressure, exactly DEPTH requests, drain in order, resume at 16
      do_reset(1'b0);
      for (int k = 0; k < 7; k++) begin
         exp_req.push_back(64'(4*k));
         exp_fetch.push_back(mk(64'(4*k), 32'(k)));
      end
      for (int c = 0; c < 20; c++) begin
         if (c == 10) bus.fetch_ready = 1'b1;
         if (c == 14) bus.stall_fetch = 1'b1;
         @(negedge clk);
         if (c == 4) check("B_occ_c4", 64'(bus.occupancy), 64'd3);
         if (c == 9) begin
            check("B_occ_full", 64'(bus.occupancy), 64'd4);
            check("B_req_full", 64'(bus.imem_req), 64'd0);
         end
         if (c == 11) check("B_resume_addr", bus.imem_addr, 64'd16);
         if (c == 19) check("B_occ_end", 64'(bus.occupancy), 64'd0);
         next_cycle();
      end
      check_drained("B");

      // C: redirect to 0x100 the cycle after the request to 0x20
      do_reset(1'b0);
      bus.fetch_ready = 1'b1;
      for (int k = 0; k <= 8; k++) exp_req.push_back(64'(4*k));
      for (int k = 0; k <= 6; k++) exp_fetch.push_back(mk(64'(4*k), 32'(k)));
      for (int k = 0; k < 4; k++) begin
         exp_req.push_back(64'h100 + 64'(4*k));
         exp_fetch.push_back(mk(64'h100 + 64'(4*k), 32'h40 + 32'(k)));
      end
      for (int c = 0; c < 18; c++) begin
         if (c == 9) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 64'h100;
         end
         if (c == 10) bus.redirect_valid = 1'b0;
         if (c == 14) bus.stall_fetch = 1'b1;
         @(negedge clk);
         if (c == 9) begin
            check("C_req_in_redirect", 64'(bus.imem_req), 64'd0);
            check("C_valid_in_redirect", 64'(bus.fetch_valid), 64'd1);
         end
         if (c == 10) begin
            check("C_req_t1", 64'(bus.imem_req), 64'd1);
            check("C_flushed", 64'(bus.occupancy), 64'd0);
         end
         if (c == 11) check("C_valid_t2", 64'(bus.fetch_valid), 64'd0);
         if (c == 12) begin
            check("C_valid_t3", 64'(bus.fetch_valid), 64'd1);
            check("C_pc_t3", bus.fetch_pc, 64'h100);
         end
         next_cycle();
      end
      check_drained("C");

      // D: back-to-back redirects 0x200 then unaligned 0x303 -> 0x300
      do_reset(1'b0);
      bus.fetch_ready = 1'b1;
      for (int k = 0; k < 4; k++) exp_req.push_back(64'(4*k));
      exp_fetch.push_back(mk(64'h0, 32'h0));
      exp_fetch.push_back(mk(64'h4, 32'h1));
      for (int k = 0; k < 3; k++) begin
         exp_req.push_back(64'h300 + 64'(4*k));
         exp_fetch.push_back(mk(64'h300 + 64'(4*k), 32'hC0 + 32'(k)));
      end
      for (int c = 0; c < 13; c++) begin
         if (c == 4) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 64'h200;
         end
         if (c == 5) bus.redirect_pc = 64'h303;
         if (c == 6) bus.redirect_valid = 1'b0;
         if (c == 9) bus.stall_fetch = 1'b1;
         @(negedge clk);
         if (c == 5) check("D_no_req_2nd", 64'(bus.imem_req), 64'd0);
         if (c == 6) check("D_aligned_addr", bus.imem_addr, 64'h300);
         if (c == 7) check("D_valid_c7", 64'(bus.fetch_valid), 64'd0);
         if (c == 8) check("D_first_pc", bus.fetch_pc, 64'h300);
         next_cycle();
      end
      check_drained("D");

      // E: stall for 3 cycles mid-stream
      do_reset(1'b0);
      bus.fetch_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_req.push_back(64'(4*k));
         exp_fetch.push_back(mk(64'(4*k), 32'(k)));
      end
      for (int c = 0; c < 15; c++) begin
         if (c == 5) bus.stall_fetch = 1'b1;
         if (c == 8) bus.stall_fetch = 1'b0;
         if (c == 11) bus.stall_fetch = 1'b1;
         @(negedge clk);
         if (c >= 5 && c <= 7) check("E_stall_req", 64'(bus.imem_req), 64'd0);
         if (c == 6) begin
            check("E_pending_valid", 64'(bus.fetch_valid), 64'd1);
            check("E_pending_pc", bus.fetch_pc, 64'd16);
         end
         if (c == 8) check("E_resume_addr", bus.imem_addr, 64'd20);
         next_cycle();
      end
      check_drained("E");

      // F: asynchronous reset between edges mid-stream
      do_reset(1'b0);
      bus.fetch_ready = 1'b1;
      for (int k = 0; k < 6; k++) exp_req.push_back(64'(4*k));
      for (int k = 0; k < 4; k++) exp_fetch.push_back(mk(64'(4*k), 32'(k)));
      for (int c = 0; c < 5; c++) next_cycle();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("F_async_occ", 64'(bus.occupancy), 64'd0);
      check("F_async_valid", 64'(bus.fetch_valid), 64'd0);
      check("F_async_req", 64'(bus.imem_req), 64'd0);
      check_drained("F1");
      next_cycle();
      next_cycle();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_req.push_back(64'(4*k));
         exp_fetch.push_back(mk(64'(4*k), 32'(k)));
      end
      for (int c = 0; c < 9; c++) begin
         if (c == 4) bus.stall_fetch = 1'b1;
         @(negedge clk);
         if (c == 0) check("F_restart_addr", bus.imem_addr, 64'd0);
         if (c == 1) check("F_valid_c1", 64'(bus.fetch_valid), 64'd0);
         next_cycle();
      end
      check_drained("F2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
